minimig_rstreq: RTL and testbench
=================================

# minimig_rstreq

Reset request sequencer that drives the master reset input (`mrst`) of the system reset generator. It collects reset requests from the keyboard, the OSD/host and the CPU halt detector, and holds `mrst` for a guaranteed minimum time. It then watches the generated global reset (`sys_reset`) through its assert and release phases, so each request produces exactly one complete, observable system reset.

## Interface

Parameters:
- `HOLD_TICKS`, 16: minimum `mrst` assertion, in `clk7_en` ticks (2..255).
- `TIMEOUT_TICKS`, 4095: release watchdog limit, in `clk7_en` ticks (12-bit).

Ports:
- `clk`  in  1  bus clock.
- `_rst`  in  1  asynchronous, active-low reset.
- `clk7_en`  in  1  7 MHz clock enable; all FSM and counter updates occur only on enable cycles.
- `kbd_rst`  in  1  keyboard reset request, level; held while Ctrl-Amiga-Amiga is pressed.
- `osd_rst`  in  1  host/OSD reset request; single-`clk` pulse, may fall outside `clk7_en`.
- `cpu_halt`  in  1  CPU double-bus-fault halt, level.
- `sys_reset`  in  1  global synchronous reset from the reset generator (feedback).
- `mrst`  out  1  master reset request to the reset generator, registered.
- `busy`  out  1  high in every state except IDLE.
- `cause`  out  3  sticky reset cause: {cpu, osd, kbd}.
- `timeout`  out  1  sticky flag: a release wait expired.

## Operation

- `osd_rst` is captured on any `clk` edge into `osd_pend`. `osd_pend` clears only on the enable cycle that consumes it, so no pulse is lost.
- `req = kbd_rst | osd_pend | cpu_halt`, evaluated on enable cycles.
- FSM states: IDLE, ASSERT, HOLD, REL.
- **IDLE**
  - On `req`: load `cause` with the request bits, set `mrst=1`, load `tick=HOLD_TICKS-1`, clear `ack`, consume `osd_pend`, go to ASSERT.
- **ASSERT**
  - `tick` decrements per enable and saturates at 0.
  - `ack` is set when `sys_reset=1` is seen.
  - Further requests OR into `cause`, and `osd_pend` is consumed (merged).
  - When `tick==0` and `ack==1`: if `kbd_rst|cpu_halt` go to HOLD, else go to REL.
- **HOLD**
  - `mrst` stays 1 while `kbd_rst|cpu_halt`; requests merge into `cause`.
  - When both are low: go to REL.
- **REL**
  - `mrst=0`. Wait for `sys_reset==0`, then go to IDLE.
  - An `osd_rst` arriving here stays pending and starts a new cycle on the next enable in IDLE.
- Reset (`_rst` low, asynchronous): state IDLE, `mrst=0`, `busy=0`, `cause=0`, `timeout=0`, `osd_pend=0`, counters 0. Reset mid-operation therefore releases `mrst` immediately.

## Timing

- Registered outputs change only on `clk7_en` cycles, except `osd_pend`.
- `mrst` rises on the first enable cycle where `req` is seen; request to `mrst` latency is one enable tick.
- Minimum `mrst` high time is `HOLD_TICKS` enable ticks.
- `mrst` cannot fall before `ack`. Because the reset generator uses a 2-stage synchronizer, `ack` needs at least 2 ticks; with `HOLD_TICKS>=2`, `tick` is normally the bound.
- `sys_reset` remains high after `mrst` falls until the generator counts its `cnt` pulses; REL absorbs this.
- `busy` equals `(state!=IDLE)`, registered with the state.
- Simultaneous requests in IDLE: all set bits load into `cause`.
- An `osd_rst` pulse coinciding with its consuming enable edge is consumed; it is not re-pended.

## Configuration

- `MINIMIG_RSTREQ_TIMEOUT_EN` defined:
  - A 12-bit watchdog counts enable ticks in ASSERT-awaiting-`ack` and in REL.
  - On reaching `TIMEOUT_TICKS`: set `timeout`, force `mrst=0`, go to IDLE.
  - The watchdog clears on every state change.
- Not defined: no watchdog; ASSERT and REL wait indefinitely; `timeout` is tied 0.

## Test plan

- `osd_rst` 1-clk pulse between enables, `sys_reset` follows `mrst` with 2-tick lag and releases 4 ticks after `mrst` falls -> `mrst` high for exactly 16 ticks, `cause=3'b010`, `busy` low one tick after `sys_reset` falls.
- `kbd_rst` held 40 ticks -> `mrst` high about 40 ticks (HOLD), then REL; `cause=3'b001`.
- `cpu_halt` rises during ASSERT of an OSD cycle -> single cycle, `cause=3'b110`; `osd_rst` pulse during REL -> second cycle starts one enable tick after IDLE.
- `_rst` asserted mid-HOLD -> `mrst`, `busy`, `cause` go 0 immediately without a clock; after release, no cycle runs unless a request is present.
- With `MINIMIG_RSTREQ_TIMEOUT_EN` and `sys_reset` stuck at 0 -> `mrst` falls after 4095 ticks, `timeout=1`, FSM in IDLE. Without the macro -> `mrst` stays 1 indefinitely and `timeout=0`.

Source files
------------

// File: rtl/minimig_rstreq.sv
// Reset request sequencer: merges keyboard/OSD/CPU-halt requests into one mrst pulse
// and tracks sys_reset through assert and release. Define MINIMIG_RSTREQ_TIMEOUT_EN for the release watchdog.
module minimig_rstreq #(
    parameter int unsigned HOLD_TICKS    = 16,
    parameter int unsigned TIMEOUT_TICKS = 4095
) (
    input  logic       clk,
    input  logic       _rst,
    input  logic       clk7_en,
    input  logic       kbd_rst,
    input  logic       osd_rst,
    input  logic       cpu_halt,
    input  logic       sys_reset,
    output logic       mrst,
    output logic       busy,
    output logic [2:0] cause,
    output logic       timeout,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2,
        REL    = 2'd3
    } state_e;

    localparam logic [7:0] TICK_INIT = 8'(HOLD_TICKS - 1);

    state_e     state_q, state_d;
    logic       mrst_q, mrst_d;
    logic       busy_q, busy_d;
    logic       ack_q, ack_d;
    logic       timeout_q, timeout_d;
    logic       osd_pend_q, osd_pend_d;
    logic [2:0] cause_q, cause_d;
    logic [7:0] tick_q, tick_d;
    logic       osd_req;
    logic       hold_req;
    logic [2:0] req_bits;
    logic       req;
    logic       consume;
    logic       wdog_expired;

    // A pulse landing on the consuming enable edge is seen directly, so it is never re-pended.
    assign osd_req  = osd_pend_q | osd_rst;
    assign hold_req = kbd_rst | cpu_halt;
    assign req_bits = {cpu_halt, osd_req, kbd_rst};
    assign req      = |req_bits;

`ifdef MINIMIG_RSTREQ_TIMEOUT_EN
    localparam logic [11:0] WDOG_LAST = 12'(TIMEOUT_TICKS - 1);

    logic [11:0] wdog_q, wdog_d;
    logic        wdog_run;

    assign wdog_run     = (state_q == REL) || ((state_q == ASSERT) && !ack_q);
    assign wdog_expired = wdog_run && (wdog_q == WDOG_LAST);

    always_comb begin
        wdog_d = wdog_q;
        if (clk7_en) begin
            if (state_d != state_q) begin
                wdog_d = '0;
            end else if (wdog_run) begin
                wdog_d = wdog_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mrst_d    = mrst_q;
        cause_d   = cause_q;
        tick_d    = tick_q;
        ack_d     = ack_q;
        timeout_d = timeout_q;
        consume   = 1'b0;
        if (clk7_en) begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        cause_d = req_bits;
                        mrst_d  = 1'b1;
                        tick_d  = TICK_INIT;
                        ack_d   = 1'b0;
                        consume = 1'b1;
                        state_d = ASSERT;
                    end
                end
                ASSERT: begin
                    cause_d = cause_q | req_bits;
                    consume = 1'b1;
                    if (tick_q != 8'd0) tick_d = tick_q - 8'd1;
                    if (sys_reset) ack_d = 1'b1;
                    if ((tick_q == 8'd0) && ack_q) begin
                        if (hold_req) begin
                            state_d = HOLD;
                        end else begin
                            mrst_d  = 1'b0;
                            state_d = REL;
                        end
                    end else if (wdog_expired) begin
                        timeout_d = 1'b1;
                        mrst_d    = 1'b0;
                        state_d   = IDLE;
                    end
                end
                HOLD: begin
                    cause_d = cause_q | req_bits;
                    consume = 1'b1;
                    if (!hold_req) begin
                        mrst_d  = 1'b0;
                        state_d = REL;
                    end
                end
                REL: begin
                    // osd_pend is deliberately left alone here; it restarts a cycle from IDLE.
                    mrst_d = 1'b0;
                    if (!sys_reset) begin
                        state_d = IDLE;
                    end else if (wdog_expired) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        osd_pend_d = osd_pend_q;
        if (clk7_en && consume) begin
            osd_pend_d = 1'b0;
        end else if (osd_rst) begin
            osd_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q    <= IDLE;
            mrst_q     <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            timeout_q  <= 1'b0;
            osd_pend_q <= 1'b0;
            cause_q    <= 3'd0;
            tick_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            mrst_q     <= mrst_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            timeout_q  <= timeout_d;
            osd_pend_q <= osd_pend_d;
            cause_q    <= cause_d;
            tick_q     <= tick_d;
        end
    end

    assign mrst      = mrst_q;
    assign busy      = busy_q;
    assign cause     = cause_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_minimig_rstreq.sv
// Scoreboard bench for minimig_rstreq: expected output changes (value + tick distance) are queued
// by the stimulus and checked by a monitor. Honors MINIMIG_RSTREQ_TIMEOUT_EN.
module tb_minimig_rstreq;
    localparam logic [15:0] DT_ANY = 16'hFFFF;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       clk7_en   = 1'b0;
    logic       kbd_rst   = 1'b0;
    logic       osd_rst   = 1'b0;
    logic       cpu_halt  = 1'b0;
    logic       sys_reset = 1'b0;
    logic       mrst;
    logic       busy;
    logic [2:0] cause;
    logic       timeout;
    logic [1:0] state_dbg;

    // expected entry = {tick distance from previous change (DT_ANY = don't care), {mrst,busy,cause,timeout}}
    logic [21:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    int          en_cnt = 0;
    int          last_en = 0;
    int          ev_idx = 0;
    int          mon_dt;
    logic [5:0]  mon_cur;
    logic [5:0]  prev_outs = 6'd0;
    logic [21:0] mon_e;

    logic [1:0]  phase = 2'd0;
    int          hi_cnt = 0;
    int          lo_cnt = 0;
    logic        gen_stuck = 1'b0;

    minimig_rstreq #(
        .HOLD_TICKS   (16),
        .TIMEOUT_TICKS(4095)
    ) dut (
        .clk      (clk),
        ._rst     (rst_n),
        .clk7_en  (clk7_en),
        .kbd_rst  (kbd_rst),
        .osd_rst  (osd_rst),
        .cpu_halt (cpu_halt),
        .sys_reset(sys_reset),
        .mrst     (mrst),
        .busy     (busy),
        .cause    (cause),
        .timeout  (timeout),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / enable / reset-generator model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clk7_en) en_cnt <= en_cnt + 1;
    end

    // Reset generator model: sys_reset visible 3 ticks after mrst rises (2-tick lag) and
    // 5 ticks after mrst falls (generator sees the fall 1 tick late, then 4 ticks of release).
    always @(negedge clk) begin
        if (clk7_en) begin
            if (mrst) begin
                lo_cnt = 0;
                if (hi_cnt < 3) hi_cnt = hi_cnt + 1;
                if (hi_cnt >= 3 && !gen_stuck) sys_reset = 1'b1;
            end else begin
                hi_cnt = 0;
                if (sys_reset) begin
                    lo_cnt = lo_cnt + 1;
                    if (lo_cnt >= 5) begin
                        sys_reset = 1'b0;
                        lo_cnt    = 0;
                    end
                end
            end
        end
        phase   = phase + 2'd1;
        clk7_en = (phase == 2'd0);
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        mon_cur = {mrst, busy, cause, timeout};
        if (mon_cur !== prev_outs) begin
            mon_dt = en_cnt - last_en;
            n_cmp  = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_change%0d: outs %b dt %0d, required no change", ev_idx, mon_cur, mon_dt);
            end else begin
                mon_e = exp_q.pop_front();
                if ((mon_cur !== mon_e[5:0]) || ((mon_e[21:6] != DT_ANY) && (mon_dt != int'(mon_e[21:6])))) begin
                    n_fail = n_fail + 1;
                    $display("FAIL event%0d: outs %b dt %0d, required outs %b dt %0d",
                             ev_idx, mon_cur, mon_dt, mon_e[5:0], int'(mon_e[21:6]));
                end
            end
            ev_idx    = ev_idx + 1;
            prev_outs = mon_cur;
            last_en   = en_cnt;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_en(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!clk7_en) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic expect_out(input logic [5:0] outs, input logic [15:0] dt);
        exp_q.push_back({dt, outs});
    endtask

    task automatic osd_pulse();
        osd_rst = 1'b1;
        @(negedge clk);
        osd_rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        n_cmp = n_cmp + 1;
        if (got !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            wait_en(1);
            i = i + 1;
        end
        @(posedge clk);
        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL %s_drain: %0d expected events pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("reset_outs", {2'b00, mrst, busy, cause, timeout}, 8'h00);
        check("reset_state", {6'd0, state_dbg}, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_en(2);

        // OSD pulse between enables: 16-tick mrst, busy drops 5 ticks after mrst falls
        expect_out(6'b11_010_0, DT_ANY);
        expect_out(6'b01_010_0, 16'd16);
        expect_out(6'b00_010_0, 16'd5);
        osd_pulse();
        drain("osd_cycle", 40);

        // keyboard held 40 ticks: HOLD stretches mrst to 40 ticks
        wait_en(1);
        expect_out(6'b11_001_0, DT_ANY);
        expect_out(6'b01_001_0, 16'd40);
        expect_out(6'b00_001_0, 16'd5);
        kbd_rst = 1'b1;
        wait_en(25);
        check("kbd_hold_state", {6'd0, state_dbg}, 8'd2);
        wait_en(15);
        kbd_rst = 1'b0;
        drain("kbd_cycle", 40);

        // CPU halt merged into an OSD cycle, then OSD during REL starts a second cycle
        wait_en(1);
        expect_out(6'b11_010_0, DT_ANY);
        expect_out(6'b11_110_0, 16'd5);
        expect_out(6'b01_110_0, 16'd11);
        expect_out(6'b00_110_0, 16'd5);
        expect_out(6'b11_010_0, 16'd1);
        expect_out(6'b01_010_0, 16'd16);
        expect_out(6'b00_010_0, 16'd5);
        osd_pulse();
        wait_en(5);
        cpu_halt = 1'b1;
        wait_en(5);
        cpu_halt = 1'b0;
        check("merge_assert_state", {6'd0, state_dbg}, 8'd1);
        wait_en(8);
        osd_pulse();
        drain("merge_cycle", 80);

        // asynchronous reset in the middle of HOLD
        wait_en(1);
        expect_out(6'b11_001_0, DT_ANY);
        kbd_rst = 1'b1;
        wait_en(25);
        expect_out(6'b00_000_0, DT_ANY);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_outs", {2'b00, mrst, busy, cause, timeout}, 8'h00);
        check("async_reset_state", {6'd0, state_dbg}, 8'h00);
        kbd_rst = 1'b0;
        wait_en(10);
        rst_n = 1'b1;
        wait_en(10);
        drain("async_reset", 1);
        check("post_reset_idle", {6'd0, mrst, busy}, 8'h00);

        // sys_reset stuck low
        @(posedge clk);
        gen_stuck = 1'b1;
        wait_en(1);
        expect_out(6'b11_010_0, DT_ANY);
`ifdef MINIMIG_RSTREQ_TIMEOUT_EN
        expect_out(6'b00_010_1, 16'd4095);
        osd_pulse();
        drain("watchdog", 4200);
        check("watchdog_state", {6'd0, state_dbg}, 8'h00);
`else
        osd_pulse();
        wait_en(300);
        check("stuck_outs", {5'd0, mrst, busy, timeout}, 8'b110);
        expect_out(6'b01_010_0, DT_ANY);
        expect_out(6'b00_010_0, 16'd5);
        @(posedge clk);
        gen_stuck = 1'b0;
        drain("stuck_release", 40);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "time limit reached");
    end
endmodule
